// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Purpose:
//   Parallel-in / serial-out shifter with a ready/valid handshake on both sides.
//   A word is captured on the input handshake and then leaves one bit per
//   output beat. The bit order is selectable (MSB- or LSB-first). The last bit
//   of every word is flagged. A new word can be loaded on the same cycle as the
//   final beat of the current word, so back-to-back words leave with no idle
//   cycle between them.
//
// Parameters:
//   width_p      bits per word (width_p >= 2)
//   lsb_first_p  0: data_i[width_p-1] leaves first; 1: data_i[0] leaves first
//   reset_val_p  shift-register contents after reset
//
// Ports:
//   clk_i      in   1        clock, rising-edge active
//   reset_n_i  in   1        asynchronous active-low reset
//   valid_i    in   1        producer offers a word on data_i
//   ready_o    out  1        block accepts a word this cycle
//   data_i     in   width_p  parallel word, captured on valid_i & ready_o
//   valid_o    out  1        serial bit on data_o is valid
//   ready_i    in   1        consumer takes the bit this cycle
//   data_o     out  1        current serial bit
//   last_o     out  1        current bit is the final bit of the word
// -----------------------------------------------------------------------------
module shift_serializer #(
  parameter int unsigned        width_p     = 8,
  parameter bit                 lsb_first_p = 1'b0,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               data_o,
  output logic               last_o
);

  localparam int unsigned         cnt_w_lp    = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(width_p - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [width_p-1:0]  r_shift;
  logic [width_p-1:0]  w_shift_next;
  logic [width_p-1:0]  w_shifted;
  logic [cnt_w_lp-1:0] r_cnt;
  logic [cnt_w_lp-1:0] w_cnt_next;

  logic w_in_shift;
  logic w_last;
  logic w_ready;
  logic w_accept;
  logic w_beat;
  logic w_out_bit;

  // The output end of the register depends on the bit order. Shifting always
  // moves bits toward that end and fills the vacated position with zero.
  generate
    if (lsb_first_p) begin : g_lsb_first
      assign w_shifted = {1'b0, r_shift[width_p-1:1]};
      assign w_out_bit = r_shift[0];
    end else begin : g_msb_first
      assign w_shifted = {r_shift[width_p-2:0], 1'b0};
      assign w_out_bit = r_shift[width_p-1];
    end
  endgenerate

  // State register. The word in flight is discarded on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_shift <= reset_val_p;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;

    w_in_shift = (r_state == SHIFT);
    w_last     = w_in_shift && (r_cnt == cnt_last_lp);

    // In SHIFT the input side opens only while the final bit is being taken.
    // This is the combinational ready_i -> ready_o path that removes the bubble
    // between words. Everything is masked while reset is held.
    w_ready  = reset_n_i && (!w_in_shift || (ready_i && w_last));
    w_accept = valid_i && w_ready;
    w_beat   = reset_n_i && w_in_shift && ready_i;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shift_next = data_i;
          w_cnt_next   = '0;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_beat) begin
          if (!w_last) begin
            w_shift_next = w_shifted;
            w_cnt_next   = r_cnt + cnt_w_lp'(1);
          end else if (w_accept) begin
            // Final beat and a new word arrive together, so stay in SHIFT.
            w_shift_next = data_i;
            w_cnt_next   = '0;
          end else begin
            // The register keeps its last value. Only the counter rewinds.
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // valid_o is independent of ready_i. While a beat is stalled, data_o and
    // last_o follow registered state only, so they hold steady.
    ready_o = w_ready;
    valid_o = reset_n_i && w_in_shift;
    data_o  = reset_n_i && w_in_shift && w_out_bit;
    last_o  = reset_n_i && w_last;
  end

endmodule

// File: tb/tb_shift_serializer.sv
module tb_shift_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [7:0] data_i = 8'h00;

  logic rdy_m, vld_m, dat_m, lst_m;
  logic rdy_l, vld_l, dat_l, lst_l;

  always #5 clk = ~clk;

  shift_serializer #(.width_p(8), .lsb_first_p(1'b0)) dut_msb (
    .clk_i(clk), .reset_n_i(rst_n),
    .valid_i(valid_i), .ready_o(rdy_m), .data_i(data_i),
    .valid_o(vld_m), .ready_i(ready_i), .data_o(dat_m), .last_o(lst_m)
  );

  shift_serializer #(.width_p(8), .lsb_first_p(1'b1)) dut_lsb (
    .clk_i(clk), .reset_n_i(rst_n),
    .valid_i(valid_i), .ready_o(rdy_l), .data_i(data_i),
    .valid_o(vld_l), .ready_i(ready_i), .data_o(dat_l), .last_o(lst_l)
  );

  // Scoreboards of expected {data, last} per beat, one per bit order.
  logic [1:0] qm[$];
  logic [1:0] ql[$];

  int npass  = 0;
  int ntotal = 0;
  int ccnt   = 0;
  int vcnt   = 0;
  bit last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      qm.push_back({w[7-i], (i == 7)});
      ql.push_back({w[i], (i == 7)});
    end
  endtask

  // Compare the current output beat against the scoreboard front. A stalled
  // beat is compared without popping, so it must match the same entry again.
  task automatic mon(input bit lsb);
    logic v, d, l;
    logic [1:0] e;
    int sz;
    string sfx;
    sfx = lsb ? "l" : "m";
    if (lsb) begin v = vld_l; d = dat_l; l = lst_l; sz = ql.size(); end
    else     begin v = vld_m; d = dat_m; l = lst_m; sz = qm.size(); end
    if (v === 1'b1) begin
      chk($sformatf("sb_has_bit_%s", sfx), (sz != 0), 1);
      if (sz != 0) begin
        e = lsb ? ql[0] : qm[0];
        chk($sformatf("%s_data_%s", ready_i ? "beat" : "hold", sfx), d, e[1]);
        chk($sformatf("%s_last_%s", ready_i ? "beat" : "hold", sfx), l, e[0]);
        if (ready_i) begin
          if (lsb) void'(ql.pop_front());
          else     void'(qm.pop_front());
        end
      end
    end
  endtask

  // One clock cycle: check at the falling edge, then return 1 time unit after
  // the rising edge so the caller can change inputs.
  task automatic tick();
    @(negedge clk);
    mon(1'b0);
    mon(1'b1);
    last_acc = valid_i && rdy_m;
    if (last_acc) push_word(data_i);
    ccnt++;
    if (vld_m) vcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit hold);
    valid_i  = 1'b1;
    data_i   = w;
    last_acc = 1'b0;
    for (int k = 0; k < 20 && !last_acc; k++) tick();
    chk("accept_timeout", last_acc, 1);
    if (!hold) valid_i = 1'b0;
    chk("latency_valid_m", vld_m, 1);
    chk("latency_valid_l", vld_l, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (qm.size() != 0 || ql.size() != 0); k++) tick();
    chk("drain_m", qm.size(), 0);
    chk("drain_l", ql.size(), 0);
  endtask

  initial begin
    // 1. Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      valid_i = 1'($urandom);
      ready_i = 1'($urandom);
      data_i  = 8'($urandom);
      @(negedge clk);
      chk("rst_valid_m", vld_m, 0);
      chk("rst_ready_m", rdy_m, 0);
      chk("rst_valid_l", vld_l, 0);
      chk("rst_ready_l", rdy_l, 0);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    chk("release_ready_m", rdy_m, 1);
    chk("release_valid_m", vld_m, 0);
    chk("release_ready_l", rdy_l, 1);

    // 2/3. Single word C4, both bit orders, ready_i high.
    send(8'hC4, 1'b0);
    ccnt = 0; vcnt = 0;
    drain();
    chk("word_cycles", ccnt, 8);
    chk("word_valid_cycles", vcnt, 8);
    chk("idle_ready_m", rdy_m, 1);
    chk("idle_valid_m", vld_m, 0);
    chk("idle_last_m", lst_m, 0);

    // 4. Back-to-back C4 then 3B with no bubble.
    send(8'hC4, 1'b1);
    ccnt = 0; vcnt = 0;
    send(8'h3B, 1'b0);
    chk("b2b_second_accept_cycle", ccnt, 8);
    drain();
    chk("b2b_cycles", ccnt, 16);
    chk("b2b_valid_cycles", vcnt, 16);

    // 5. Backpressure for 3 cycles at bit 2.
    send(8'hC4, 1'b0);
    ccnt = 0;
    tick();
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready_m", rdy_m, 0);
      chk("stall_valid_m", vld_m, 1);
    end
    ready_i = 1'b1;
    drain();
    chk("stall_cycles", ccnt, 11);

    // Final-bit ready path: ready_o follows ready_i on the last beat only.
    send(8'hA5, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    ready_i = 1'b0;
    #1;
    chk("lastbeat_ready_low_m", rdy_m, 0);
    chk("lastbeat_last_m", lst_m, 1);
    chk("lastbeat_last_l", lst_l, 1);
    ready_i = 1'b1;
    #1;
    chk("lastbeat_ready_high_m", rdy_m, 1);
    chk("lastbeat_ready_high_l", rdy_l, 1);
    drain();

    // 6. Asynchronous reset in the middle of a word at bit 4.
    send(8'hC4, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid_m", vld_m, 0);
    chk("async_ready_m", rdy_m, 0);
    chk("async_data_m", dat_m, 0);
    chk("async_last_m", lst_m, 0);
    chk("async_valid_l", vld_l, 0);
    qm.delete();
    ql.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready_m", rdy_m, 1);
    chk("post_rst_valid_m", vld_m, 0);
    for (int i = 0; i < 3; i++) tick();
    send(8'hFF, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) tick();
    chk("final_valid_m", vld_m, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
